// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter: pipeline priority, late-result FIFO, bypass lookup
// Optional per-register busy scoreboard enabled by defining WB_SCOREBOARD_EN.
module regfile_wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_addr,
    input  logic [31:0] pipe_data,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_addr,
    input  logic [31:0] md_data,
    output logic        wr,
    output logic [4:0]  addr3,
    output logic [31:0] data3,
    input  logic [4:0]  q_addr1,
    input  logic [4:0]  q_addr2,
    output logic        byp_hit1,
    output logic [31:0] byp_data1,
    output logic        byp_hit2,
    output logic [31:0] byp_data2,
    output logic [31:0] busy
);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    logic              r_valid [DEPTH];
    logic [4:0]        r_addr  [DEPTH];
    logic [31:0]       r_data  [DEPTH];
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W:0]    r_count;
    logic              r_wr;
    logic [4:0]        r_addr3;
    logic [31:0]       r_data3;

    logic w_pipe_wr;
    logic w_pop;
    logic w_push;
    logic w_head_valid;

    assign md_ready     = (r_count != FULL_COUNT);
    assign w_pipe_wr    = pipe_valid && (pipe_addr != 5'd0);
    assign w_pop        = !w_pipe_wr && (r_count != '0);
    // Zero-destination results are acknowledged but never occupy a slot.
    assign w_push       = md_valid && md_ready && (md_addr != 5'd0);
    assign w_head_valid = r_valid[r_rd_ptr];

    assign wr    = r_wr;
    assign addr3 = r_addr3;
    assign data3 = r_data3;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_valid[i] <= 1'b0;
                r_addr[i]  <= 5'd0;
                r_data[i]  <= 32'd0;
            end
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_wr     <= 1'b0;
            r_addr3  <= 5'd0;
            r_data3  <= 32'd0;
        end else begin
            // A pipeline write is newer than anything still queued for the same register.
            for (int i = 0; i < DEPTH; i++) begin
                if (w_pipe_wr && r_valid[i] && (r_addr[i] == pipe_addr)) begin
                    r_valid[i] <= 1'b0;
                end
            end
            if (w_pop) begin
                r_valid[r_rd_ptr] <= 1'b0;
                r_rd_ptr          <= r_rd_ptr + 1'b1;
            end
            if (w_push) begin
                r_valid[r_wr_ptr] <= !(w_pipe_wr && (md_addr == pipe_addr));
                r_addr[r_wr_ptr]  <= md_addr;
                r_data[r_wr_ptr]  <= md_data;
                r_wr_ptr          <= r_wr_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase

            if (w_pipe_wr) begin
                r_wr    <= 1'b1;
                r_addr3 <= pipe_addr;
                r_data3 <= pipe_data;
            end else if (w_pop) begin
                r_wr <= w_head_valid;
                if (w_head_valid) begin
                    r_addr3 <= r_addr[r_rd_ptr];
                    r_data3 <= r_data[r_rd_ptr];
                end
            end else begin
                r_wr <= 1'b0;
            end
        end
    end

    // Walk oldest to newest so the newest valid match wins over older ones and the output register.
    function automatic logic [32:0] lookup(input logic [4:0] q);
        logic [32:0]      res;
        logic [PTR_W-1:0] idx;
        res = 33'd0;
        if (q != 5'd0) begin
            if (r_wr && (r_addr3 == q)) begin
                res = {1'b1, r_data3};
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = r_rd_ptr + PTR_W'(i);
                if (r_valid[idx] && (r_addr[idx] == q)) begin
                    res = {1'b1, r_data[idx]};
                end
            end
        end
        return res;
    endfunction

    logic [32:0] w_byp1;
    logic [32:0] w_byp2;

    assign w_byp1    = lookup(q_addr1);
    assign w_byp2    = lookup(q_addr2);
    assign byp_hit1  = w_byp1[32];
    assign byp_data1 = w_byp1[31:0];
    assign byp_hit2  = w_byp2[32];
    assign byp_data2 = w_byp2[31:0];

`ifdef WB_SCOREBOARD_EN
    logic [31:0] w_busy;

    always_comb begin
        w_busy = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i]) begin
                w_busy[r_addr[i]] = 1'b1;
            end
        end
        w_busy[0] = 1'b0;
    end

    assign busy = w_busy;
`else
    assign busy = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - scoreboard bench for regfile_wb_arbiter against a queue-based reference model
module tb_regfile_wb_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        pipe_valid;
    logic [4:0]  pipe_addr;
    logic [31:0] pipe_data;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_addr;
    logic [31:0] md_data;
    logic        wr;
    logic [4:0]  addr3;
    logic [31:0] data3;
    logic [4:0]  q_addr1;
    logic [4:0]  q_addr2;
    logic        byp_hit1;
    logic [31:0] byp_data1;
    logic        byp_hit2;
    logic [31:0] byp_data2;
    logic [31:0] busy;

    regfile_wb_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
        .clk(clk), .reset(reset),
        .pipe_valid(pipe_valid), .pipe_addr(pipe_addr), .pipe_data(pipe_data),
        .md_valid(md_valid), .md_ready(md_ready), .md_addr(md_addr), .md_data(md_data),
        .wr(wr), .addr3(addr3), .data3(data3),
        .q_addr1(q_addr1), .q_addr2(q_addr2),
        .byp_hit1(byp_hit1), .byp_data1(byp_data1),
        .byp_hit2(byp_hit2), .byp_data2(byp_data2),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct { bit v; logic [4:0] a; logic [31:0] d; } ent_t;
    typedef struct { int c; logic [4:0] a; logic [31:0] d; } wexp_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    bit          in_reset = 1'b1;
    ent_t        mq[$];
    wexp_t       eq[$];
    wexp_t       mon_w;
    logic [31:0] model_rf [32];
    logic [31:0] dut_rf   [32];
    bit          mo_wr = 1'b0;
    logic [4:0]  mo_addr = 5'd0;
    logic [31:0] mo_data = 32'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic logic [32:0] m_byp(input logic [4:0] q);
        logic [32:0] r;
        r = 33'd0;
        if (q == 5'd0) return r;
        if (mo_wr && mo_addr == q) r = {1'b1, mo_data};
        foreach (mq[i]) if (mq[i].v && mq[i].a == q) r = {1'b1, mq[i].d};
        return r;
    endfunction

    function automatic logic [31:0] m_busy();
        logic [31:0] b;
        b = 32'd0;
        foreach (mq[i]) if (mq[i].v) b[mq[i].a] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    task automatic add_exp(input logic [4:0] a, input logic [31:0] d);
        eq.push_back('{c: cyc + 1, a: a, d: d});
        model_rf[a] = d;
        mo_wr   = 1'b1;
        mo_addr = a;
        mo_data = d;
    endtask

    task automatic cycle(input bit pv, input logic [4:0] pa, input logic [31:0] pd,
                         input bit mv, input logic [4:0] ma, input logic [31:0] md,
                         input logic [4:0] q1, input logic [4:0] q2);
        logic [32:0] e;
        bit          pipe_wr, pop, push;
        ent_t        head;
        @(negedge clk);
        pipe_valid = pv; pipe_addr = pa; pipe_data = pd;
        md_valid = mv; md_addr = ma; md_data = md;
        q_addr1 = q1; q_addr2 = q2;
        #1;
        chk("md_ready", {31'd0, md_ready}, (mq.size() < 4) ? 32'd1 : 32'd0);
        e = m_byp(q1);
        chk("byp_hit1", {31'd0, byp_hit1}, {31'd0, e[32]});
        chk("byp_data1", byp_data1, e[31:0]);
        e = m_byp(q2);
        chk("byp_hit2", {31'd0, byp_hit2}, {31'd0, e[32]});
        chk("byp_data2", byp_data2, e[31:0]);
`ifdef WB_SCOREBOARD_EN
        chk("busy", busy, m_busy());
`else
        chk("busy", busy, 32'd0);
`endif
        pipe_wr = pv && (pa != 5'd0);
        pop     = !pipe_wr && (mq.size() > 0);
        push    = mv && (mq.size() < 4) && (ma != 5'd0);
        if (pipe_wr) begin
            foreach (mq[i]) if (mq[i].a == pa) mq[i].v = 1'b0;
            add_exp(pa, pd);
        end else if (pop) begin
            head = mq.pop_front();
            if (head.v) add_exp(head.a, head.d);
            else mo_wr = 1'b0;
        end else begin
            mo_wr = 1'b0;
        end
        if (push) mq.push_back('{v: !(pipe_wr && ma == pa), a: ma, d: md});
    endtask

    task automatic idle();
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    endtask

    always @(posedge clk) begin
        #2;
        if (!in_reset) begin
            while (eq.size() > 0 && eq[0].c < cyc) begin
                mon_w = eq.pop_front();
                checks++;
                failures++;
                $display("FAIL write_missing actual=none expected=addr %0d data %h at cycle %0d", mon_w.a, mon_w.d, mon_w.c);
            end
            if (wr === 1'b1) begin
                dut_rf[addr3] = data3;
                if (eq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_write actual=addr %0d data %h expected=no write", addr3, data3);
                end else begin
                    mon_w = eq.pop_front();
                    chk("wr_addr", {27'd0, addr3}, {27'd0, mon_w.a});
                    chk("wr_data", data3, mon_w.d);
                    chk("wr_cycle", cyc, mon_w.c);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 32; i++) begin
            model_rf[i] = 32'd0;
            dut_rf[i]   = 32'd0;
        end
        reset = 1'b0;
        pipe_valid = 1'b0; pipe_addr = 5'd0; pipe_data = 32'd0;
        md_valid = 1'b0; md_addr = 5'd0; md_data = 32'd0;
        q_addr1 = 5'd0; q_addr2 = 5'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_wr", {31'd0, wr}, 32'd0);
        chk("reset_addr3", {27'd0, addr3}, 32'd0);
        chk("reset_data3", data3, 32'd0);
        chk("reset_md_ready", {31'd0, md_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        in_reset = 1'b0;

        // pipeline priority over a queued result
        cycle(1'b1, 5'd8, 32'h11, 1'b1, 5'd9, 32'hAA, 5'd9, 5'd8);
        cycle(1'b1, 5'd8, 32'h11, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
        cycle(1'b1, 5'd8, 32'h11, 1'b0, 5'd0, 32'd0, 5'd9, 5'd8);
        idle();
        idle();

        // fill the FIFO while the pipeline holds the port
        for (int i = 0; i < 6; i++)
            cycle(1'b1, 5'd3, 32'h300 + i, 1'b1, 5'(16 + i), 32'h100 + i, 5'(16 + i), 5'd3);
        chk("full_md_ready", {31'd0, md_ready}, 32'd0);
        idle();
        chk("full_first_pop_ready", {31'd0, md_ready}, 32'd0);
        idle();
        chk("full_after_pop_ready", {31'd0, md_ready}, 32'd1);
        repeat (4) idle();

        // squash of a queued result by a newer pipeline write
        cycle(1'b1, 5'd11, 32'h1, 1'b1, 5'd10, 32'h5, 5'd10, 5'd0);
        cycle(1'b1, 5'd10, 32'h7, 1'b0, 5'd0, 32'd0, 5'd10, 5'd11);
        chk("squash_byp_before", byp_data1, 32'h5);
        cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd0);
        chk("squash_byp_after", byp_data1, 32'h7);
        idle();
        idle();
        chk("squash_rf10", dut_rf[10], 32'h7);

        // bypass with two queued results for the same register
        cycle(1'b1, 5'd1, 32'h31, 1'b1, 5'd12, 32'h1, 5'd0, 5'd0);
        cycle(1'b1, 5'd2, 32'h32, 1'b1, 5'd12, 32'h2, 5'd0, 5'd0);
        cycle(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 5'd12, 5'd0);
        chk("byp_newest_hit", {31'd0, byp_hit1}, 32'd1);
        chk("byp_newest_data", byp_data1, 32'h2);
        chk("byp_zero_hit", {31'd0, byp_hit2}, 32'd0);
        chk("byp_zero_data", byp_data2, 32'd0);
        repeat (3) idle();

        // zero-address traffic
        cycle(1'b1, 5'd4, 32'h44, 1'b1, 5'd0, 32'hDEAD, 5'd0, 5'd0);
        cycle(1'b1, 5'd5, 32'h55, 1'b1, 5'd6, 32'h66, 5'd0, 5'd0);
        cycle(1'b1, 5'd0, 32'h99, 1'b0, 5'd0, 32'd0, 5'd6, 5'd0);
        idle();
        chk("zero_pipe_pop_rf6", dut_rf[6], 32'h66);
        idle();

        // asynchronous reset while draining
        cycle(1'b1, 5'd1, 32'hA1, 1'b1, 5'd2, 32'hB2, 5'd0, 5'd0);
        cycle(1'b1, 5'd1, 32'hA1, 1'b1, 5'd3, 32'hB3, 5'd0, 5'd0);
        cycle(1'b1, 5'd1, 32'hA1, 1'b1, 5'd4, 32'hB4, 5'd0, 5'd0);
        idle();
        @(posedge clk);
        #4;
        in_reset = 1'b1;
        reset = 1'b0;
        #1;
        chk("midreset_wr", {31'd0, wr}, 32'd0);
        chk("midreset_addr3", {27'd0, addr3}, 32'd0);
        chk("midreset_data3", data3, 32'd0);
        chk("midreset_md_ready", {31'd0, md_ready}, 32'd1);
        mq.delete();
        eq.delete();
        mo_wr = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        in_reset = 1'b0;
        repeat (3) idle();

        // randomized traffic
        for (int n = 0; n < 2000; n++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        repeat (8) idle();
        @(posedge clk);
        #3;
        chk("final_exp_queue_empty", eq.size(), 32'd0);
        chk("final_model_fifo_empty", mq.size(), 32'd0);
        for (int r = 0; r < 32; r++) chk($sformatf("regfile_%0d", r), dut_rf[r], model_rf[r]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
